// File: rtl/synth_pkg.sv
// Constants and sample type shared by the synth and the I2S transmitter.
// slot_bit() picks the serial bit for a given slot position.
package synth_pkg;

  localparam int SAMPLE_W   = 24;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_POS_W = $clog2(SLOT_W);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Position 0 is the I2S one-bit delay; positions past the sample are padding.
  function automatic logic slot_bit(input sample_t s, input logic [SLOT_POS_W-1:0] p);
    logic bit_val;
    bit_val = 1'b0;
    if (p != '0 && p <= SLOT_POS_W'(SAMPLE_W))
      bit_val = s[SLOT_POS_W'(SAMPLE_W) - p];
    return bit_val;
  endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/word clock generator: divides CLK down to SCLK and counts bit slots.
// fall strobes in the CLK cycle whose rising edge produces the SCLK falling edge.
module i2s_clkgen
  import synth_pkg::*;
#(
  parameter int SCLK_HALF = 8
) (
  input  logic                 CLK,
  input  logic                 RESET,
  output logic                 sclk,
  output logic                 lrclk,
  output logic                 fall,
  output logic [BIT_CNT_W-1:0] bit_next
);

  localparam int DIV_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  logic [DIV_W-1:0]     div_cnt_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic                 sclk_reg;
  logic                 lrclk_reg;
  logic                 wrap;

  assign wrap     = (div_cnt_reg == DIV_W'(SCLK_HALF - 1));
  assign fall     = wrap & sclk_reg;
  // Six-bit counter wraps 63 -> 0 on its own, marking the frame boundary.
  assign bit_next = bit_cnt_reg + BIT_CNT_W'(1);
  assign sclk     = sclk_reg;
  assign lrclk    = lrclk_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      sclk_reg    <= 1'b0;
      lrclk_reg   <= 1'b0;
    end else begin
      if (wrap) begin
        div_cnt_reg <= '0;
        sclk_reg    <= ~sclk_reg;
      end else begin
        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
      end
      if (fall) begin
        bit_cnt_reg <= bit_next;
        lrclk_reg   <= bit_next[BIT_CNT_W-1];
      end
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Mono I2S transmitter: pops one sample per frame from the FIFO and plays it
// on both channels, 24 data bits MSB first in 32-bit slots.
module i2s_tx
  import synth_pkg::*;
#(
  parameter int SCLK_HALF = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                FIFO_EMPTY,
  input  logic [SAMPLE_W-1:0] FIFO_DATA,
  output logic                FIFO_READ,
  output logic                SCLK,
  output logic                LRCLK,
  output logic                SDATA,
  output logic                UNDERRUN
);

  logic                 fall;
  logic [BIT_CNT_W-1:0] bit_next;
  logic                 fetch;
  logic                 load;

  sample_t cur_reg;
  sample_t next_reg;
  logic    sdata_reg;
  logic    fifo_read_reg;
  logic    underrun_reg;
  logic    capture_reg;

  i2s_clkgen #(
    .SCLK_HALF(SCLK_HALF)
  ) u_clkgen (
    .CLK     (CLK),
    .RESET   (RESET),
    .sclk    (SCLK),
    .lrclk   (LRCLK),
    .fall    (fall),
    .bit_next(bit_next)
  );

  assign fetch = fall && (bit_next == BIT_CNT_W'(FRAME_BITS - 2));
  assign load  = fall && (bit_next == '0);

  assign FIFO_READ = fifo_read_reg;
  assign UNDERRUN  = underrun_reg;
  assign SDATA     = sdata_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cur_reg       <= '0;
      next_reg      <= '0;
      sdata_reg     <= 1'b0;
      fifo_read_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      capture_reg   <= 1'b0;
    end else begin
      fifo_read_reg <= fetch & ~FIFO_EMPTY;
      underrun_reg  <= fetch & FIFO_EMPTY;
      // FIFO read data lands one CLK after the strobe; grab it then.
      capture_reg   <= fifo_read_reg;
      if (fetch && FIFO_EMPTY)
        next_reg <= '0;
      else if (capture_reg)
        next_reg <= FIFO_DATA;
      if (load)
        cur_reg <= next_reg;
      if (fall)
        sdata_reg <= slot_bit(cur_reg, bit_next[SLOT_POS_W-1:0]);
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx at SCLK_HALF=8: a cycle-indexed reference model of
// the frame plus per-frame hand-computed sample words and strobe counts.
module tb_i2s_tx;

  localparam int SCLK_HALF = 8;
  localparam int BIT_CLK   = 2 * SCLK_HALF;
  localparam int FRAME_CLK = 64 * BIT_CLK;
  localparam int FETCH_N   = 62 * BIT_CLK;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        FIFO_EMPTY;
  logic [23:0] FIFO_DATA;
  logic        FIFO_READ;
  logic        SCLK;
  logic        LRCLK;
  logic        SDATA;
  logic        UNDERRUN;

  i2s_tx #(.SCLK_HALF(SCLK_HALF)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA (FIFO_DATA),
    .FIFO_READ (FIFO_READ),
    .SCLK      (SCLK),
    .LRCLK     (LRCLK),
    .SDATA     (SDATA),
    .UNDERRUN  (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  logic [4:0] obs_vec;
  assign obs_vec = {SCLK, LRCLK, SDATA, FIFO_READ, UNDERRUN};

  int          vectors = 0;
  int          errors  = 0;
  int          n;
  logic [23:0] fifo_q[$];
  logic [23:0] cur_m, next_m;
  logic [4:0]  exp_vec;
  logic        rd_seen, noise_en;
  logic [23:0] word_l, word_r;
  logic        pad_err;
  int          rd_cnt, ur_cnt, rd_at, ur_at, first_rise, first_fall;

  task automatic clear_frame_obs();
    word_l  = '0;
    word_r  = '0;
    pad_err = 1'b0;
    rd_cnt  = 0;
    ur_cnt  = 0;
    rd_at   = -1;
    ur_at   = -1;
  endtask

  // Called at posedge+1 with RESET high; the next rising edge is edge 1.
  task automatic release_reset();
    RESET      = 1'b0;
    n          = 0;
    cur_m      = '0;
    next_m     = '0;
    rd_seen    = 1'b0;
    first_rise = -1;
    first_fall = -1;
    clear_frame_obs();
  endtask

  // One CLK: drive inputs, step, emulate the FIFO, update model and observations.
  task automatic tick();
    int   nu, b, p;
    logic emp;
    nu = n + 1;
    if (noise_en && (nu % FRAME_CLK) != FETCH_N) FIFO_EMPTY = 1'($urandom_range(0, 1));
    else FIFO_EMPTY = (fifo_q.size() == 0);
    emp = FIFO_EMPTY;
    @(posedge CLK);
    #1;
    n = nu;
    if (rd_seen && fifo_q.size() > 0) FIFO_DATA = fifo_q.pop_front();
    else FIFO_DATA = 24'($urandom);
    rd_seen = FIFO_READ;

    b = (n / BIT_CLK) % 64;
    p = b % 32;
    if (n % FRAME_CLK == 0) begin
      cur_m = next_m;
      clear_frame_obs();
    end
    exp_vec    = '0;
    exp_vec[4] = ((n / SCLK_HALF) % 2) == 1;
    exp_vec[3] = (b >= 32);
    exp_vec[2] = (p >= 1 && p <= 24) ? cur_m[24 - p] : 1'b0;
    if (n % FRAME_CLK == FETCH_N) begin
      if (!emp) begin
        exp_vec[1] = 1'b1;
        next_m     = fifo_q[0];
      end else begin
        exp_vec[0] = 1'b1;
        next_m     = '0;
      end
    end

    if (FIFO_READ) begin
      rd_cnt++;
      rd_at = n % FRAME_CLK;
      $display("read      n=%0d frame=%0d pos=%0d", n, n / FRAME_CLK, rd_at);
    end
    if (UNDERRUN) begin
      ur_cnt++;
      ur_at = n % FRAME_CLK;
      $display("underrun  n=%0d frame=%0d pos=%0d", n, n / FRAME_CLK, ur_at);
    end
    if (SCLK === 1'b1 && first_rise < 0) first_rise = n;
    if (SCLK === 1'b0 && first_rise >= 0 && first_fall < 0) first_fall = n;
    if (n % BIT_CLK == SCLK_HALF) begin
      if (p >= 1 && p <= 24) begin
        if (b < 32) word_l[24 - p] = SDATA;
        else        word_r[24 - p] = SDATA;
      end else if (SDATA !== 1'b0) begin
        pad_err = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    RESET      = 1'b1;
    FIFO_EMPTY = 1'b1;
    FIFO_DATA  = '0;
    noise_en   = 1'b0;
    rd_seen    = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    vectors++;
    if (obs_vec !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %05b want 00000", obs_vec);
    end
    fifo_q.push_back(24'hA5F00F);
    release_reset();
    repeat (FRAME_CLK - 1) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (first_rise !== 8) begin errors++; $display("FAIL first_rise got %0d want 8", first_rise); end
    vectors++;
    if (first_fall !== 16) begin errors++; $display("FAIL first_fall got %0d want 16", first_fall); end
    vectors++;
    if ({word_l, word_r, pad_err} !== 49'd0) begin
      errors++;
      $display("FAIL frame0_silent got %06h/%06h pad=%0b want 000000/000000 pad=0", word_l, word_r, pad_err);
    end
    vectors++;
    if (rd_cnt !== 1 || rd_at !== 992) begin
      errors++;
      $display("FAIL frame0_read got cnt=%0d pos=%0d want cnt=1 pos=992", rd_cnt, rd_at);
    end
  endtask

  task automatic test_sample();
    repeat (FRAME_CLK) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (word_l !== 24'hA5F00F) begin errors++; $display("FAIL sample_left got %06h want a5f00f", word_l); end
    vectors++;
    if (word_r !== 24'hA5F00F) begin errors++; $display("FAIL sample_right got %06h want a5f00f", word_r); end
    vectors++;
    if (pad_err !== 1'b0) begin errors++; $display("FAIL sample_pad got %0b want 0", pad_err); end
    vectors++;
    if (ur_cnt !== 1 || ur_at !== 992 || rd_cnt !== 0) begin
      errors++;
      $display("FAIL empty_fetch got ur=%0d@%0d rd=%0d want ur=1@992 rd=0", ur_cnt, ur_at, rd_cnt);
    end
  endtask

  task automatic test_underrun();
    fifo_q.push_back(24'h800000);
    fifo_q.push_back(24'h7FFFFF);
    repeat (FRAME_CLK) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
      end
    end
    vectors++;
    if ({word_l, word_r, pad_err} !== 49'd0) begin
      errors++;
      $display("FAIL underrun_silent got %06h/%06h pad=%0b want 000000/000000 pad=0", word_l, word_r, pad_err);
    end
    vectors++;
    if (rd_cnt !== 1 || ur_cnt !== 0) begin
      errors++;
      $display("FAIL underrun_recover got rd=%0d ur=%0d want rd=1 ur=0", rd_cnt, ur_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      repeat (FRAME_CLK) begin
        tick();
        vectors++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
        end
      end
      vectors++;
      if (word_l[23] !== (f == 0)) begin
        errors++;
        $display("FAIL b2b_msb frame%0d got %0b want %0b", f, word_l[23], (f == 0));
      end
      vectors++;
      if (word_l !== ((f == 0) ? 24'h800000 : 24'h7FFFFF) || word_r !== word_l || pad_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_word frame%0d got %06h/%06h pad=%0b want %06h both pad=0",
                 f, word_l, word_r, pad_err, (f == 0) ? 24'h800000 : 24'h7FFFFF);
      end
      vectors++;
      if (rd_cnt !== ((f == 0) ? 1 : 0) || (f == 0 && rd_at !== 992)) begin
        errors++;
        $display("FAIL b2b_reads frame%0d got cnt=%0d pos=%0d want cnt=%0d pos=992", f, rd_cnt, rd_at, (f == 0) ? 1 : 0);
      end
    end
  endtask

  task automatic test_empty_noise();
    noise_en = 1'b1;
    fifo_q.push_back(24'h123456);
    for (int f = 0; f < 2; f++) begin
      repeat (FRAME_CLK) begin
        tick();
        vectors++;
        if (obs_vec !== exp_vec) begin
          errors++;
          $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
        end
      end
      vectors++;
      if (rd_cnt + ur_cnt !== 1 || (f == 0 && rd_at !== 992) || (f == 1 && ur_at !== 992)) begin
        errors++;
        $display("FAIL noise_strobes frame%0d got rd=%0d@%0d ur=%0d@%0d want one strobe @992",
                 f, rd_cnt, rd_at, ur_cnt, ur_at);
      end
      vectors++;
      if (word_l !== ((f == 0) ? 24'h000000 : 24'h123456) || word_r !== word_l) begin
        errors++;
        $display("FAIL noise_word frame%0d got %06h/%06h want %06h both",
                 f, word_l, word_r, (f == 0) ? 24'h000000 : 24'h123456);
      end
    end
    noise_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    fifo_q.push_back(24'h654321);
    repeat (FRAME_CLK + 40 * BIT_CLK + 5) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (word_l !== 24'h654321) begin errors++; $display("FAIL mid_left got %06h want 654321", word_l); end
    fifo_q.push_back(24'h000001);
    #2;
    RESET = 1'b1;
    #1;
    vectors++;
    if (obs_vec !== 5'b0) begin
      errors++;
      $display("FAIL async_reset got %05b want 00000", obs_vec);
    end
    repeat (3) begin
      @(posedge CLK);
      #1;
      vectors++;
      if (obs_vec !== 5'b0) begin
        errors++;
        $display("FAIL held_reset got %05b want 00000", obs_vec);
      end
    end
    FIFO_DATA = 24'h654321;
    release_reset();
    repeat (FRAME_CLK - 1) begin
      tick();
      vectors++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("FAIL pins n=%0d got{sclk,lr,sd,rd,ur} %05b want %05b", n, obs_vec, exp_vec);
      end
    end
    vectors++;
    if (first_rise !== 8 || first_fall !== 16) begin
      errors++;
      $display("FAIL restart_sclk got rise=%0d fall=%0d want rise=8 fall=16", first_rise, first_fall);
    end
    vectors++;
    if ({word_l, word_r, pad_err} !== 49'd0) begin
      errors++;
      $display("FAIL restart_silent got %06h/%06h pad=%0b want 000000/000000 pad=0", word_l, word_r, pad_err);
    end
    vectors++;
    if (rd_cnt !== 1 || rd_at !== 992 || ur_cnt !== 0) begin
      errors++;
      $display("FAIL restart_read got rd=%0d@%0d ur=%0d want rd=1@992 ur=0", rd_cnt, rd_at, ur_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_sample();
    test_underrun();
    test_back_to_back();
    test_empty_noise();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
